// File: rtl/seg_scan_bcd.sv
// Multiplexed seven-segment driver. A double-dabble converter sits behind a ready/valid load.
// It adds an optional colour-glyph digit, leading-zero blanking and overflow dashes.
module seg_scan_bcd #(
  parameter int NUM_DIGITS  = 4,
  parameter int VAL_W       = 8,
  parameter int GLYPH_EN    = 1,
  parameter int REFRESH_CNT = 195312,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VAL_W-1:0]      value,
  input  logic                  value_valid,
  output logic                  ready,
  input  logic [3:0]            glyph,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] dig,
  output logic [6:0]            seg
);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int ND    = NUM_DIGITS - GLYPH_EN;
  localparam int BW    = 4 * ND;
  localparam int BIT_W = $clog2(VAL_W);
  localparam int CNT_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [31:0] MAXV = 32'(pow10(ND) - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t                  state_q;
  logic                    ready_q;
  logic [VAL_W-1:0]        shift_q;
  logic [BW-1:0]           scratch_q;
  logic [BW-1:0]           scratchAdj_d;
  logic [BW-1:0]           bcd_q;
  logic                    ovfPend_q;
  logic                    overflow_q;
  logic [BIT_W-1:0]        bitCnt_q;
  logic [CNT_W-1:0]        refCnt_q;
  logic [IDX_W-1:0]        scanIdx_q;
  logic [NUM_DIGITS-1:0]   dig_q;
  logic [NUM_DIGITS-1:0]   dig_d;
  logic [NUM_DIGITS-1:0]   blank_d;
  logic [6:0]              seg_q;
  logic [6:0]              seg_d;
  logic [4*NUM_DIGITS-1:0] bcdPad;

  function automatic logic [6:0] digitSeg(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [6:0] glyphSeg(input logic [3:0] g);
    case (g)
      4'd0:    return 7'b1111010;
      4'd1:    return 7'b1100000;
      4'd2:    return 7'b0100001;
      4'd3:    return 7'b1001100;
      4'd4:    return 7'b1100011;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction applied to the scratch nibbles before each shift.
  always_comb begin
    scratchAdj_d = scratch_q;
    for (int n = 0; n < ND; n++) begin
      if (scratch_q[4*n +: 4] >= 4'd5) scratchAdj_d[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      shift_q    <= '0;
      scratch_q  <= '0;
      ovfPend_q  <= 1'b0;
      bitCnt_q   <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (value_valid) begin
            shift_q   <= value;
            scratch_q <= '0;
            ovfPend_q <= (32'(value) > MAXV);
            bitCnt_q  <= '0;
            ready_q   <= 1'b0;
            state_q   <= CONV;
          end
        end
        CONV: begin
          scratch_q <= {scratchAdj_d[BW-2:0], shift_q[VAL_W-1]};
          shift_q   <= {shift_q[VAL_W-2:0], 1'b0};
          bitCnt_q  <= bitCnt_q + BIT_W'(1);
          if (bitCnt_q == BIT_W'(VAL_W - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          bcd_q      <= scratch_q;
          overflow_q <= ovfPend_q;
          ready_q    <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refCnt_q  <= '0;
      scanIdx_q <= '0;
    end else if (refCnt_q == CNT_W'(REFRESH_CNT - 1)) begin
      refCnt_q  <= '0;
      scanIdx_q <= (scanIdx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scanIdx_q + IDX_W'(1);
    end else begin
      refCnt_q <= refCnt_q + CNT_W'(1);
    end
  end

  // Padding lets the glyph position index the BCD without running off the end.
  assign bcdPad = (4*NUM_DIGITS)'(bcd_q);

  always_comb begin
    logic lzRun;
    lzRun   = 1'b1;
    blank_d = '0;
    for (int k = ND - 1; k >= 0; k--) begin
      lzRun = lzRun & (bcd_q[4*k +: 4] == 4'd0);
      if (BLANK_LZ != 0 && k >= 1) blank_d[k] = lzRun;
    end
    seg_d = SEG_BLANK;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scanIdx_q == IDX_W'(k)) begin
        if (GLYPH_EN != 0 && k == NUM_DIGITS - 1) seg_d = glyphSeg(glyph);
        else if (overflow_q)                      seg_d = SEG_DASH;
        else if (blank_d[k])                      seg_d = SEG_BLANK;
        else                                      seg_d = digitSeg(bcdPad[4*k +: 4]);
      end
    end
    dig_d = ~(NUM_DIGITS'(1) << scanIdx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig_q <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      dig_q <= dig_d;
      seg_q <= seg_d;
    end
  end

  assign ready    = ready_q;
  assign overflow = overflow_q;
  assign dig      = dig_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Randomised bench for seg_scan_bcd: three parameterisations share one clock and reset,
// and every sample is compared to an arithmetic model of the displayed decimal value.
module tb_seg_scan_bcd;
  localparam int RC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [7:0]  valA = '0, valB = '0;
  logic [19:0] valC = '0;
  logic        vvA = 1'b0, vvB = 1'b0, vvC = 1'b0;
  logic [3:0]  glA = '0, glB = '0, glC = '0;
  logic        rdyA, rdyB, rdyC, ovA, ovB, ovC;
  logic [3:0]  digA;
  logic [2:0]  digB;
  logic [5:0]  digC;
  logic [6:0]  segA, segB, segC;

  seg_scan_bcd #(.NUM_DIGITS(4), .VAL_W(8), .GLYPH_EN(1), .REFRESH_CNT(RC), .BLANK_LZ(1)) dutA (
    .clk(clk), .rst_n(rst_n), .value(valA), .value_valid(vvA), .ready(rdyA),
    .glyph(glA), .overflow(ovA), .dig(digA), .seg(segA));
  seg_scan_bcd #(.NUM_DIGITS(3), .VAL_W(8), .GLYPH_EN(1), .REFRESH_CNT(RC), .BLANK_LZ(1)) dutB (
    .clk(clk), .rst_n(rst_n), .value(valB), .value_valid(vvB), .ready(rdyB),
    .glyph(glB), .overflow(ovB), .dig(digB), .seg(segB));
  seg_scan_bcd #(.NUM_DIGITS(6), .VAL_W(20), .GLYPH_EN(0), .REFRESH_CNT(RC), .BLANK_LZ(1)) dutC (
    .clk(clk), .rst_n(rst_n), .value(valC), .value_valid(vvC), .ready(rdyC),
    .glyph(glC), .overflow(ovC), .dig(digC), .seg(segC));

  int vectors = 0;
  int miscompares = 0;
  int cycSinceRel = 0;
  int ndig[3] = '{4, 3, 6};
  int vw[3]   = '{8, 8, 20};
  int gen[3]  = '{1, 1, 0};
  int modelVal[3]   = '{0, 0, 0};
  int modelGlyph[3] = '{0, 0, 0};
  logic [6:0] numTab[10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  logic [6:0] glyphTab[5] = '{7'b1111010, 7'b1100000, 7'b0100001, 7'b1001100, 7'b1100011};
  logic [7:0] capDig[$];
  logic [6:0] capSeg[$];
  int         capCyc[$];

  // Cycles since reset release; the scan position follows directly from it.
  always @(posedge clk) cycSinceRel <= (!rst_n) ? -1 : cycSinceRel + 1;

  function automatic longint pw10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic longint maxVal(input int d);
    return pw10(ndig[d] - gen[d]) - 1;
  endfunction

  function automatic logic [7:0] expDig(input int d, input int n);
    return ~(8'd1 << ((n / RC) % ndig[d]));
  endfunction

  function automatic logic [6:0] expSeg(input int d, input int n);
    int     k;
    longint v;
    k = (n / RC) % ndig[d];
    v = modelVal[d];
    if (gen[d] == 1 && k == ndig[d] - 1)
      return (modelGlyph[d] < 5) ? glyphTab[modelGlyph[d]] : 7'b1111111;
    if (v > maxVal(d)) return 7'b1111110;
    if (k >= 1 && v < pw10(k)) return 7'b1111111;
    return numTab[int'((v / pw10(k)) % 10)];
  endfunction

  function automatic logic getReady(input int d);
    case (d)
      0:       return rdyA;
      1:       return rdyB;
      default: return rdyC;
    endcase
  endfunction

  function automatic logic getOvf(input int d);
    case (d)
      0:       return ovA;
      1:       return ovB;
      default: return ovC;
    endcase
  endfunction

  function automatic logic [7:0] getDig(input int d);
    case (d)
      0:       return {4'hF, digA};
      1:       return {5'h1F, digB};
      default: return {2'b11, digC};
    endcase
  endfunction

  function automatic logic [6:0] getSeg(input int d);
    case (d)
      0:       return segA;
      1:       return segB;
      default: return segC;
    endcase
  endfunction

  task automatic setInputs(input int d, input int v, input logic vld);
    case (d)
      0:       begin valA = v[7:0];  vvA = vld; end
      1:       begin valB = v[7:0];  vvB = vld; end
      default: begin valC = v[19:0]; vvC = vld; end
    endcase
  endtask

  task automatic setGlyph(input int d, input int g);
    modelGlyph[d] = g;
    case (d)
      0:       glA = g[3:0];
      1:       glB = g[3:0];
      default: glC = g[3:0];
    endcase
  endtask

  // Pulses a load and counts the negedge samples with ready low.
  task automatic applyStimulus(input int d, input int v, output int lowCnt, output bit timedOut);
    setInputs(d, v, 1'b1);
    @(negedge clk);
    setInputs(d, v, 1'b0);
    lowCnt = 0;
    while (getReady(d) === 1'b0 && lowCnt < 200) begin
      lowCnt++;
      @(negedge clk);
    end
    timedOut = (lowCnt >= 200);
    modelVal[d] = v;
  endtask

  task automatic captureFrame(input int d, input int cycles);
    capDig.delete();
    capSeg.delete();
    capCyc.delete();
    repeat (cycles) begin
      @(negedge clk);
      capDig.push_back(getDig(d));
      capSeg.push_back(getSeg(d));
      capCyc.push_back(cycSinceRel);
    end
  endtask

  task automatic test_reset(input bit midConv);
    if (midConv) begin
      setInputs(0, 200, 1'b1);
      @(negedge clk);
      setInputs(0, 200, 1'b0);
      repeat (3) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (getDig(d) !== 8'hFF) begin
        miscompares++; $display("[TB] FAIL reset dig dut%0d: got %b, want all ones", d, getDig(d));
      end
      vectors++;
      if (getSeg(d) !== 7'b1111111) begin
        miscompares++; $display("[TB] FAIL reset seg dut%0d: got %b, want 1111111", d, getSeg(d));
      end
      vectors++;
      if (getReady(d) !== 1'b1) begin
        miscompares++; $display("[TB] FAIL reset ready dut%0d: got %b, want 1", d, getReady(d));
      end
      vectors++;
      if (getOvf(d) !== 1'b0) begin
        miscompares++; $display("[TB] FAIL reset overflow dut%0d: got %b, want 0", d, getOvf(d));
      end
      modelVal[d] = 0;
    end
    rst_n = 1'b1;
    if (midConv) begin
      captureFrame(0, 40);
      for (int i = 0; i < capCyc.size(); i++) begin
        vectors++;
        if (capDig[i] !== expDig(0, capCyc[i])) begin
          miscompares++; $display("[TB] FAIL abort dig cyc %0d: got %b, want %b", capCyc[i], capDig[i], expDig(0, capCyc[i]));
        end
        vectors++;
        if (capSeg[i] !== expSeg(0, capCyc[i])) begin
          miscompares++; $display("[TB] FAIL abort seg cyc %0d: got %b, want %b", capCyc[i], capSeg[i], expSeg(0, capCyc[i]));
        end
      end
    end
  endtask

  task automatic test_display(input int d, input int v, input int g, input int cycles);
    int lowCnt;
    bit timedOut;
    setGlyph(d, g);
    applyStimulus(d, v, lowCnt, timedOut);
    vectors++;
    if (timedOut || lowCnt != vw[d] + 1) begin
      miscompares++; $display("[TB] FAIL busy dut%0d value %0d: ready low %0d cycles, want %0d", d, v, lowCnt, vw[d] + 1);
    end
    vectors++;
    if (getOvf(d) !== (longint'(v) > maxVal(d))) begin
      miscompares++; $display("[TB] FAIL overflow dut%0d value %0d: got %b", d, v, getOvf(d));
    end
    captureFrame(d, cycles);
    for (int i = 0; i < capCyc.size(); i++) begin
      vectors++;
      if (capDig[i] !== expDig(d, capCyc[i])) begin
        miscompares++; $display("[TB] FAIL dig dut%0d value %0d cyc %0d: got %b, want %b", d, v, capCyc[i], capDig[i], expDig(d, capCyc[i]));
      end
      vectors++;
      if (capSeg[i] !== expSeg(d, capCyc[i])) begin
        miscompares++; $display("[TB] FAIL seg dut%0d value %0d cyc %0d: got %b, want %b", d, v, capCyc[i], capSeg[i], expSeg(d, capCyc[i]));
      end
    end
  endtask

  task automatic test_handshake;
    int lowCnt;
    setInputs(0, 42, 1'b1);
    @(negedge clk);
    setInputs(0, 42, 1'b0);
    lowCnt = 0;
    while (getReady(0) === 1'b0 && lowCnt < 200) begin
      lowCnt++;
      setInputs(0, 200, lowCnt == 3);
      @(negedge clk);
    end
    modelVal[0] = 42;
    vectors++;
    if (lowCnt != vw[0] + 1) begin
      miscompares++; $display("[TB] FAIL handshake busy: ready low %0d cycles, want %0d", lowCnt, vw[0] + 1);
    end
    captureFrame(0, 2 * ndig[0] * RC);
    for (int i = 0; i < capCyc.size(); i++) begin
      vectors++;
      if (capSeg[i] !== expSeg(0, capCyc[i])) begin
        miscompares++; $display("[TB] FAIL handshake seg cyc %0d: got %b, want %b", capCyc[i], capSeg[i], expSeg(0, capCyc[i]));
      end
    end
  endtask

  task automatic test_back_to_back;
    int   curV, lastAcc, accCount, lastVal, guard;
    logic prevRdy, r;
    curV = int'($urandom_range(0, 255));
    setInputs(0, curV, 1'b1);
    prevRdy = 1'b1; accCount = 0; lastAcc = 0; lastVal = 0; guard = 0;
    while (accCount < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
      r = getReady(0);
      if (prevRdy && !r) begin
        if (accCount > 0) begin
          vectors++;
          if (cycSinceRel - lastAcc != vw[0] + 2) begin
            miscompares++; $display("[TB] FAIL b2b spacing: got %0d cycles, want %0d", cycSinceRel - lastAcc, vw[0] + 2);
          end
        end
        lastAcc = cycSinceRel;
        lastVal = curV;
        accCount++;
        curV = int'($urandom_range(0, 255));
        setInputs(0, curV, accCount < 3);
      end
      prevRdy = r;
    end
    setInputs(0, curV, 1'b0);
    vectors++;
    if (accCount != 3) begin
      miscompares++; $display("[TB] FAIL b2b acceptances: got %0d, want 3", accCount);
    end
    guard = 0;
    while (getReady(0) !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    modelVal[0] = lastVal;
    captureFrame(0, ndig[0] * RC);
    for (int i = 0; i < capCyc.size(); i++) begin
      vectors++;
      if (capSeg[i] !== expSeg(0, capCyc[i])) begin
        miscompares++; $display("[TB] FAIL b2b seg value %0d cyc %0d: got %b, want %b", lastVal, capCyc[i], capSeg[i], expSeg(0, capCyc[i]));
      end
    end
  endtask

  task automatic test_random;
    int d;
    for (int it = 0; it < 12; it++) begin
      d = int'($urandom_range(0, 2));
      test_display(d, int'($urandom_range(0, (1 << vw[d]) - 1)), int'($urandom_range(0, 7)), ndig[d] * RC);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset(1'b0);
    test_display(0, 157, 2, 2 * 4 * RC);
    test_display(0, 7, 2, 4 * RC);
    test_display(0, 0, 4, 4 * RC);
    test_display(1, 100, 3, 2 * 3 * RC);
    test_display(1, 99, 9, 2 * 3 * RC);
    test_handshake;
    test_back_to_back;
    test_display(2, 999999, 7, 2 * 6 * RC);
    test_random;
    test_reset(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_bcd.md
# seg_scan_bcd

Parametrised multiplexed seven-segment driver with an iterative binary-to-BCD converter and a ready/valid load handshake. It sits between the measurement/classification logic and the board's common-anode digit array. It scans `NUM_DIGITS` digits. When `GLYPH_EN=1`, the leftmost digit shows a colour letter and the remaining digits show the decimal value. It adds leading-zero blanking, overflow indication and clean reset behaviour.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: digits in the array, range 2..8.
- `VAL_W`, default 8: width of the binary input value, range 4..24.
- `GLYPH_EN`, default 1: when 1, digit `NUM_DIGITS-1` is the glyph digit.
- `REFRESH_CNT`, default 195312: clock cycles each digit stays on.
- `BLANK_LZ`, default 1: when 1, leading zeros are blanked.

Derived value: `ND = NUM_DIGITS - GLYPH_EN`, the number of numeric digits. `MAXV = 10^ND - 1`.

Ports. Reset is synchronous and active-low: `rst_n` is sampled on the rising edge of `clk`, and there is one clock.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: synchronous active-low reset.
- `value`, in, `VAL_W`: unsigned binary value to display.
- `value_valid`, in, 1: load request. Accepted on an edge where `ready=1`.
- `ready`, out, 1: converter idle and able to accept a load.
- `glyph`, in, 4: glyph code for the glyph digit.
  - 0=r, 1=b, 2=G, 3=Y, 4=u.
  - Any other code blanks the digit.
- `overflow`, out, 1: the last accepted value exceeded `MAXV`.
- `dig`, out, `NUM_DIGITS`: digit enables, active-low one-hot. `dig[0]` is the rightmost digit.
- `seg`, out, 7: segments, active-low, ordered {a,b,c,d,e,f,g}. `seg[0]` is g.

## Operation
- Reset values:
  - `dig` = all 1 and `seg` = 7'b1111111 (display dark).
  - `ready=1`, `overflow=0`.
  - Display BCD register = 0.
  - Scan index = 0, refresh counter = 0.
  - Converter is in IDLE.
- Converter FSM has three states: IDLE, CONV and COMMIT.
- **IDLE:** `ready=1`. If `value_valid=1`:
  - latch `value` into the shift register;
  - clear the scratch BCD (4*`ND` bits);
  - latch `ovf_pend = (value > MAXV)`;
  - set the bit counter to 0 and go to CONV.
- **CONV:** one bit per cycle, for `VAL_W` cycles.
  - Add 3 to every scratch nibble that is >= 5.
  - Then shift {scratch, shift reg} left by 1 in the same cycle.
  - After the `VAL_W`-th bit, go to COMMIT.
  - Bits shifted out of the top of the scratch are discarded; the overflow flag covers this case.
- **COMMIT:**
  - copy scratch into the display BCD register;
  - copy `ovf_pend` into `overflow`;
  - go to IDLE.
- `value_valid` is ignored while `ready=0`, with no queueing. The `value` input is not used after acceptance.
- `glyph` is not latched; it is sampled live every cycle.
- Scan:
  - The refresh counter counts 0..`REFRESH_CNT-1`.
  - On terminal count the counter wraps to 0 and the scan index advances.
  - The scan index wraps from `NUM_DIGITS-1` to 0.
- Output register: each cycle, `dig` and `seg` are registered together from the scan index and the current display state, so they never disagree.
- Digit content for scan index k:
  - If `GLYPH_EN=1` and k = `NUM_DIGITS-1`: glyph segments.
    - r = 1111010, b = 1100000, G = 0100001, Y = 1001100, u = 1100011.
    - Other codes = 1111111.
  - Else if `overflow=1`: dash, 1111110, on every numeric digit.
  - Else if `BLANK_LZ=1`, k >= 1, and BCD nibbles k..`ND-1` are all zero: blank, 1111111.
  - Else: decode nibble k.
    - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100.
    - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100.
    - Nibbles 10..15 cannot occur; they decode to blank.
- Digit 0 is never blanked, so a value of 0 displays "0".

## Timing
- Acceptance on edge T:
  - `ready` = 0 after T, for exactly `VAL_W+1` cycles;
  - COMMIT occurs on edge T+`VAL_W`+1;
  - `ready` = 1 and the new BCD and `overflow` are visible after that edge.
- The segment change for the active digit appears one cycle after COMMIT. Other digits update when they are next scanned.
- Back-to-back loads: `value_valid` held high gives one acceptance every `VAL_W+2` cycles.
- Reset mid-conversion aborts the conversion:
  - the display returns to the reset values;
  - the partial result is never committed.
- Each digit is on for exactly `REFRESH_CNT` cycles. The full frame is `NUM_DIGITS*REFRESH_CNT` cycles.

## Test plan
Use `REFRESH_CNT`=4 in simulation.
- **Reset:** assert `rst_n`=0 mid-scan and mid-CONV, release.
  - Expect `dig`=1111, `seg`=1111111, `ready`=1, `overflow`=0 one cycle after the reset edge.
  - Expect no commit of the aborted value.
- **Default parameters:** `value`=8'd157, pulse `value_valid`, `glyph`=2.
  - Expect `ready` low for 9 cycles.
  - Expect the frame, digit 3..0, to read: G 0100001, "1" 1001111, "5" 0100100, "7" 0001111.
- **Blanking:** `value`=7, `BLANK_LZ`=1.
  - Expect digits 2 and 1 to be 1111111 and digit 0 to be 0001111.
  - With `value`=0, expect digit 0 = 0000001.
- **Overflow:** `NUM_DIGITS`=3, `GLYPH_EN`=1, `VAL_W`=8, `value`=100.
  - Expect `overflow`=1 and both numeric digits = 1111110.
  - A following `value`=99 clears `overflow` and shows "99".
- **Handshake:** pulse `value_valid` with `value`=42, then pulse again with `value`=200 during CONV.
  - Expect the second pulse ignored and the display to settle at "42".
  - Hold `value_valid` high and expect acceptances spaced exactly 10 cycles apart.
- **Width and scan:** `NUM_DIGITS`=6, `GLYPH_EN`=0, `VAL_W`=20, `value`=999999.
  - Expect six "9" digits (0000100).
  - Expect `dig` to cycle 111110 → 111101 → … → 011111, each held 4 cycles.
  - Expect `glyph`=7 to have no effect.
